rca_seq_adder_ctrl: RTL and testbench

- Sequencing controller that performs a WIDTH-bit addition on a single shared 4-bit ripple-carry slice.
- Processes one nibble per clock, LSB nibble first, and holds the carry in a register between nibbles.
- Sits between a valid/ready operand source and a valid/ready result sink. Trades latency for area in narrow-datapath builds.

---
 rtl/rca_seq_pkg.sv | 5 +
 rtl/rca_seq_adder_ctrl_slice.sv | 12 +
 rtl/rca_seq_adder_ctrl.sv | 115 +++++++++++
 tb/tb_rca_seq_adder_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder controller.
package rca_seq_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/rca_seq_adder_ctrl_slice.sv
// Purely combinational 4-bit ripple-carry slice: {co,s} = a + b + ci.
module rca_slice
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};
endmodule

// File: rtl/rca_seq_adder_ctrl.sv
// WIDTH-bit adder built from one shared 4-bit slice, one nibble per clock, LSB first.
// Optional subtract mode enabled by defining RCA_SEQ_SUB_EN (adds the sub input).
module rca_seq_adder_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB   = WIDTH / SLICE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh, sum_nx;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] s;
  logic               c;
  logic               accept, last;
  logic [WIDTH-1:0]   b_in;
  logic               cin_in;

`ifdef RCA_SEQ_SUB_EN
  // Subtraction as A + ~B + 1: invert B once at capture, force the initial carry.
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? 1'b1 : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (idx == IDX_W'(NIB - 1));
  // New nibble enters at the top; after NIB passes the LSB nibble lands at bit 0.
  assign sum_nx   = WIDTH'({s, sum_sh} >> SLICE_W);

  rca_slice u_slice (
    .a  (a_sh[SLICE_W-1:0]),
    .b  (b_sh[SLICE_W-1:0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b_in;
            carry <= cin_in;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_nx;
          a_sh   <= a_sh >> SLICE_W;
          b_sh   <= b_sh >> SLICE_W;
          carry  <= c;
          idx    <= idx + 1'b1;
          if (last) begin
            out_valid <= 1'b1;
            sum       <= sum_nx;
            cout      <= c;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Scoreboard bench for rca_seq_adder_ctrl (WIDTH=16); covers sub mode when RCA_SEQ_SUB_EN is defined.
module tb_rca_seq_adder_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0, n_bad = 0, nres = 0, cyc = 0;
  logic [W:0]   exp_q[$];
  int           acc_q[$];
  logic         prev_ov = 1'b0;
  logic [W-1:0] last_sum;
  logic         last_cout;

  rca_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    logic [W:0] r;
`ifdef RCA_SEQ_SUB_EN
    if (sb) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else    r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
`else
    r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
`endif
    return r;
  endfunction

  // Monitor: pushes on accepted handshakes, pops on each rising out_valid.
  always @(negedge clk) begin
    logic [W:0] e;
    int acc;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        acc_q.push_back(cyc + 1);
      end
      if (out_valid && !prev_ov) begin
        nres++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result got sum=%h cout=%b, no result expected", sum, cout);
        end else begin
          e = exp_q.pop_front();
          acc = acc_q.pop_front();
          if ({cout, sum} !== e) begin
            n_bad++;
            $display("FAIL result got cout=%b sum=%h, want cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
          end
          n_cmp++;
          if (cyc - acc !== 4) begin
            n_bad++;
            $display("FAIL latency got %0d edges, want 4", cyc - acc);
          end
        end
        last_sum  = sum;
        last_cout = cout;
      end
    end
    prev_ov = out_valid;
  end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int k;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    n_cmp++;
    if (k == 50) begin
      n_bad++;
      $display("FAIL accept_timeout got in_ready=0, want 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target);
    int k;
    for (k = 0; k < 60; k++) begin
      if (nres >= target) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nres < target) begin
      n_bad++;
      $display("FAIL result_timeout got %0d results, want %0d", nres, target);
    end
  endtask

  task automatic check_last(input string nm, input logic [W-1:0] es, input logic ec);
    n_cmp++;
    if (last_sum !== es || last_cout !== ec) begin
      n_bad++;
      $display("FAIL %s got sum=%h cout=%b, want sum=%h cout=%b", nm, last_sum, last_cout, es, ec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, in_ready, cout} !== 4'b0000 || sum !== '0) begin
      n_bad++;
      $display("FAIL reset_state got ov=%b busy=%b rdy=%b cout=%b sum=%h, want all 0",
               out_valid, busy, in_ready, cout, sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset got %b, want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t;
    out_ready = 1'b1;
    t = nres + 1;
    do_op(16'h1234, 16'h4321, 1'b0);
    wait_results(t);
    check_last("basic_add", 16'h5555, 1'b0);
  endtask

  task automatic test_carry();
    int t;
    t = nres + 1;
    do_op(16'hFFFF, 16'h0001, 1'b0);
    wait_results(t);
    check_last("full_ripple", 16'h0000, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1);
    wait_results(t + 1);
    check_last("cin_only", 16'h0001, 1'b0);
  endtask

  task automatic test_backpressure();
    int t;
    out_ready = 1'b0;
    t = nres + 1;
    do_op(16'h1234, 16'h4321, 1'b0);
    wait_results(t);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 16'hAAAA ^ W'(i); b = 16'h1111;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || sum !== 16'h5555 || cout !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold got ov=%b sum=%h cout=%b rdy=%b, want ov=1 sum=5555 cout=0 rdy=0",
                 out_valid, sum, cout, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release got ov=%b busy=%b rdy=%b, want 0 0 1", out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    do_op(16'h0F0F, 16'h0101, 1'b1);
    wait_results(t + 1);
    check_last("after_backpressure", 16'h1011, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    t = nres;
    do_op(16'h8888, 16'h8888, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got ov=%b busy=%b sum=%h cout=%b, want 0 0 0000 0",
               out_valid, busy, sum, cout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (nres !== t) begin
      n_bad++;
      $display("FAIL no_pulse_after_reset got %0d results, want %0d", nres, t);
    end
    do_op(16'h00FF, 16'h0001, 1'b0);
    wait_results(t + 1);
    check_last("post_reset_add", 16'h0100, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t, k;
    logic [W-1:0] xs[3] = '{16'h1111, 16'h7FFF, 16'hABCD};
    logic [W-1:0] ys[3] = '{16'h2222, 16'h0001, 16'h5433};
    t = nres;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = xs[i]; b = ys[i]; cin = 1'b0;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_results(t + 3);
    check_last("b2b_last", 16'h0000, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (nres !== t + 3) begin
      n_bad++;
      $display("FAIL b2b_count got %0d results, want %0d", nres - t, 3);
    end
  endtask

`ifdef RCA_SEQ_SUB_EN
  task automatic test_sub();
    int t;
    t = nres;
    sub = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b0);
    wait_results(t + 1);
    check_last("sub_borrow", 16'hFFFE, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b0);
    wait_results(t + 2);
    check_last("sub_noborrow", 16'h0002, 1'b1);
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef RCA_SEQ_SUB_EN
    test_sub();
`endif
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
